zxbus_io_master: RTL and testbench
==================================

Name: zxbus_io_master

Overview:
- Bus-initiator counterpart of the card's port register file: generates Z80-style I/O read/write cycles to ports #81AB/#82AB/#83AB from a simple request/acknowledge interface.
- Used in the bench-side host model and in the planned on-board self-test controller, which drives the card's control ports without a real Z80.
- Handles address/data setup, strobe width, WAIT_n stretching and hold, and captures read data.

Parameters:
- SETUP_CYC, 2, clk cycles of address/data valid before the strobe asserts (1..15).
- STROBE_CYC, 4, minimum clk cycles the strobe stays low (1..15).
- HOLD_CYC, 2, clk cycles of address/data held after the strobe deasserts (1..15).
- PORT_LO, 8'hAB, low byte driven on zaddr[7:0].

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- req  in  1  request; sampled only while ready=1
- req_we  in  1  1 = port write, 0 = port read
- req_addr  in  2  port select: 11=#83AB, 10=#82AB, 01=#81AB, 00 = illegal
- req_wdata  in  8  write data
- ready  out  1  idle, accepting a request
- done  out  1  one-cycle pulse at transaction end
- err  out  1  valid with done; 1 = illegal address, no bus cycle
- rdata  out  8  captured read data; valid from done until the next accepted read
- zaddr  out  16  bus address
- zdata_o  out  8  bus write data
- zdata_oe  out  1  write-data output enable
- zdata_i  in  8  bus read data
- iorq_n  out  1  I/O request strobe
- rd_n  out  1  read strobe
- wr_n  out  1  write strobe
- wait_n  in  1  bus wait, active low; treated as synchronous to clk

Behaviour:
- Reset values: ready=1, done=0, err=0, rdata=8'h00, zaddr=16'h0000, zdata_o=8'h00, zdata_oe=0, iorq_n=1, rd_n=1, wr_n=1, FSM in IDLE, counter=0.
- Reset is asynchronous. Asserting it mid-cycle immediately releases all strobes and drops zdata_oe, with no done pulse. The aborted transaction is lost.
- The FSM has five states: IDLE, SETUP, STROBE, STRETCH and HOLD.
- IDLE:
  - ready=1.
  - If req=1 and req_addr=00: next cycle done=1, err=1, state stays IDLE. Bus outputs are untouched and rdata is unchanged.
  - If req=1 and req_addr≠00: latch we/addr/wdata and set ready=0. Drive zaddr={6'b100000, addr, PORT_LO}. For a write, drive zdata_o=wdata and zdata_oe=1. Load counter=SETUP_CYC-1 and go to SETUP.
- SETUP: strobes stay high. When counter=0, assert iorq_n=0 together with rd_n=0 (read) or wr_n=0 (write). Load counter=STROBE_CYC-1 and go to STROBE. Otherwise decrement the counter.
- STROBE: strobes stay low. When counter=0:
  - if wait_n=1: deassert the strobes, capture rdata<=zdata_i for a read, load counter=HOLD_CYC-1 and go to HOLD;
  - if wait_n=0: go to STRETCH.
  Otherwise decrement the counter.
- STRETCH: strobes stay low until the first cycle sampling wait_n=1. In that cycle, perform the STROBE exit actions (including read capture). There is no timeout.
- HOLD: zaddr, zdata_o and zdata_oe are held.
  - When counter=0: drop zdata_oe, pulse done=1 (err=0) and return to IDLE.
  - ready rises in the same cycle done is high.
  - zaddr keeps its last value in IDLE.
- Strobe low width is STROBE_CYC cycles plus the number of stretch cycles.
- Total cycles from the req-accept edge to the done pulse: SETUP_CYC + STROBE_CYC + stretch + HOLD_CYC.
- wr_n rises with iorq_n, so the target latches data on the rising edge with data and address still stable.
- req is ignored while ready=0. A req held high at done is taken as a new request in the following IDLE cycle, so back-to-back transactions have exactly one IDLE cycle between them.
- rd_n and wr_n are never low simultaneously. Strobes are registered outputs (glitch-free).

Test Plan:
- Write #83AB, data 8'h54, defaults: zaddr=16'h83AB; zdata_oe rises at accept; iorq_n/wr_n low for exactly 4 cycles, starting 2 cycles after accept; done 8 cycles after accept, err=0; the port model latches 8'h54.
- Read #82AB with the model returning 8'hE7: rd_n low for 4 cycles, zdata_oe stays 0, rdata=8'hE7 at done, wr_n never low.
- Write #81AB with wait_n held low for 3 cycles from the second strobe cycle: strobe low for 5 cycles (4 + 1 stretch); done 9 cycles after accept; no strobe glitch.
- req_addr=00: done=1 and err=1 one cycle after the request; iorq_n, rd_n and wr_n stay 1 and zaddr is unchanged.
- req held high for two back-to-back writes (#83AB 8'h10, then #82AB 8'h0C): exactly one IDLE cycle between them; second zaddr=16'h82AB; the model reads back both values.
- rst asserted while in STROBE: iorq_n, wr_n and zdata_oe go inactive immediately (asynchronously); ready=1 after release; no done pulse.

Source files
------------

// File: rtl/zxbus_io_master.sv
// Z80-style I/O bus initiator: turns a request/acknowledge handshake into
// port read/write cycles on #81AB/#82AB/#83AB with setup, strobe, WAIT_n stretch and hold.
module zxbus_io_master #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter logic [7:0]  PORT_LO    = 8'hAB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [15:0] zaddr,
    output logic [7:0]  zdata_o,
    output logic        zdata_oe,
    input  logic [7:0]  zdata_i,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    input  logic        wait_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_STRETCH,
        S_HOLD
    } state_t;

    localparam logic [3:0] SETUP_M1  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_M1 = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_M1   = 4'(HOLD_CYC - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        we_q, we_nx;
    logic        ready_nx, done_nx, err_nx;
    logic [7:0]  rdata_nx;
    logic [15:0] zaddr_nx;
    logic [7:0]  zdata_o_nx;
    logic        zdata_oe_nx, iorq_nx, rd_nx, wr_nx;
    logic        exit_strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            zaddr    <= '0;
            zdata_o  <= '0;
            zdata_oe <= 1'b0;
            iorq_n   <= 1'b1;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            we_q     <= we_nx;
            ready    <= ready_nx;
            done     <= done_nx;
            err      <= err_nx;
            rdata    <= rdata_nx;
            zaddr    <= zaddr_nx;
            zdata_o  <= zdata_o_nx;
            zdata_oe <= zdata_oe_nx;
            iorq_n   <= iorq_nx;
            rd_n     <= rd_nx;
            wr_n     <= wr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        we_nx       = we_q;
        ready_nx    = ready;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        rdata_nx    = rdata;
        zaddr_nx    = zaddr;
        zdata_o_nx  = zdata_o;
        zdata_oe_nx = zdata_oe;
        iorq_nx     = iorq_n;
        rd_nx       = rd_n;
        wr_nx       = wr_n;
        exit_strobe = 1'b0;

        case (state)
            S_IDLE: begin
                if (req) begin
                    if (req_addr == 2'b00) begin
                        // Illegal port: report immediately, no bus activity.
                        done_nx = 1'b1;
                        err_nx  = 1'b1;
                    end else begin
                        we_nx    = req_we;
                        ready_nx = 1'b0;
                        zaddr_nx = {6'b100000, req_addr, PORT_LO};
                        if (req_we) begin
                            zdata_o_nx  = req_wdata;
                            zdata_oe_nx = 1'b1;
                        end
                        cnt_nx   = SETUP_M1;
                        state_nx = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    iorq_nx  = 1'b0;
                    rd_nx    = we_q;
                    wr_nx    = ~we_q;
                    cnt_nx   = STROBE_M1;
                    state_nx = S_STROBE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt == '0) begin
                    if (wait_n) exit_strobe = 1'b1;
                    else        state_nx    = S_STRETCH;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_STRETCH: begin
                if (wait_n) exit_strobe = 1'b1;
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    zdata_oe_nx = 1'b0;
                    done_nx     = 1'b1;
                    ready_nx    = 1'b1;
                    state_nx    = S_IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Shared by STROBE and STRETCH: release strobes, capture read data.
        if (exit_strobe) begin
            iorq_nx  = 1'b1;
            rd_nx    = 1'b1;
            wr_nx    = 1'b1;
            if (!we_q) rdata_nx = zdata_i;
            cnt_nx   = HOLD_M1;
            state_nx = S_HOLD;
        end
    end

endmodule

// File: tb/tb_zxbus_io_master.sv
// Directed bench for zxbus_io_master: port model on the bus, scoreboard of
// expected transaction results popped at each done pulse.
module tb_zxbus_io_master;

    localparam int SETUP  = 2;
    localparam int STROBE = 4;
    localparam int HOLD   = 2;
    localparam int LAT    = 1 + SETUP + STROBE + HOLD;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req_we;
    logic [1:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        ready, done, err;
    logic [7:0]  rdata;
    logic [15:0] zaddr;
    logic [7:0]  zdata_o, zdata_i;
    logic        zdata_oe, iorq_n, rd_n, wr_n, wait_n;

    zxbus_io_master #(
        .SETUP_CYC (SETUP),
        .STROBE_CYC(STROBE),
        .HOLD_CYC  (HOLD),
        .PORT_LO   (8'hAB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .zaddr    (zaddr),
        .zdata_o  (zdata_o),
        .zdata_oe (zdata_oe),
        .zdata_i  (zdata_i),
        .iorq_n   (iorq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .wait_n   (wait_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] port_regs [4];
    assign zdata_i = (!iorq_n && !rd_n) ? port_regs[zaddr[9:8]] : 8'hFF;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       err;
        logic [7:0] rdata;
        int         lat;
        int         low;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int   low_cnt, falls, first_low, overlap, done_cyc, base_cyc;
    logic wr_seen, rd_seen, done_seen, done_err, stretch_en;
    logic [7:0] done_rdata;
    logic prev_iorq = 1'b1;
    logic prev_wr   = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        low_cnt = 0; falls = 0; first_low = 0; overlap = 0;
        wr_seen = 0; rd_seen = 0; done_seen = 0;
    endtask

    // One clock; samples at the falling edge and plays the port/wait model.
    task automatic step();
        @(negedge clk);
        if (!iorq_n && prev_iorq) begin
            falls++;
            first_low = cyc;
        end
        if (!iorq_n) low_cnt++;
        if (!rd_n && !wr_n) overlap++;
        if (!wr_n) wr_seen = 1;
        if (!rd_n) rd_seen = 1;
        if (!prev_wr && wr_n && !rst) begin
            check("iorq_rises_with_wr", iorq_n, 1'b1);
            check("oe_at_latch", zdata_oe, 1'b1);
            port_regs[zaddr[9:8]] = zdata_o;
        end
        prev_iorq = iorq_n;
        prev_wr   = wr_n;
        if (done) begin
            done_seen  = 1;
            done_cyc   = cyc;
            done_err   = err;
            done_rdata = rdata;
        end
        wait_n = !(stretch_en && falls > 0 && cyc >= first_low + 1 && cyc <= first_low + 3);
    endtask

    task automatic issue(input logic we, input logic [1:0] a, input logic [7:0] d);
        req_we = we; req_addr = a; req_wdata = d; req = 1'b1;
    endtask

    task automatic accepted(input logic [15:0] exp_zaddr, input logic exp_oe,
                            input logic [7:0] exp_wd, input logic st);
        clr_mon();
        stretch_en = st;
        base_cyc   = cyc;
        step();
        check("accept_ready", ready, 1'b0);
        check("accept_zaddr", zaddr, exp_zaddr);
        check("accept_oe", zdata_oe, exp_oe);
        if (exp_oe) check("accept_wdata", zdata_o, exp_wd);
        check("accept_strobes", {iorq_n, rd_n, wr_n}, 3'b111);
    endtask

    task automatic push(input logic we, input logic [1:0] a, input logic [7:0] d,
                        input logic e, input logic [7:0] rd, input int lat, input int low);
        exp_t x;
        x.we = we; x.addr = a; x.wdata = d; x.err = e; x.rdata = rd; x.lat = lat; x.low = low;
        sb.push_back(x);
    endtask

    task automatic wait_done();
        exp_t e;
        int n = 0;
        while (!done_seen && n < 40) begin
            step();
            n++;
        end
        e = sb.pop_front();
        check("done_seen", done_seen, 1'b1);
        check("done_err", done_err, e.err);
        check("latency", done_cyc - base_cyc, e.lat);
        check("ready_at_done", ready, 1'b1);
        if (!e.err) begin
            check("strobe_len", low_cnt, e.low);
            check("strobe_falls", falls, 1);
            check("strobe_start", first_low - base_cyc, 1 + SETUP);
            check("rd_wr_overlap", overlap, 0);
            check("wr_seen", wr_seen, e.we);
            check("rd_seen", rd_seen, !e.we);
            check("oe_after_done", zdata_oe, 1'b0);
            if (e.we) check("port_latch", port_regs[e.addr], e.wdata);
            else      check("rdata", done_rdata, e.rdata);
        end else begin
            check("err_no_strobe", falls, 0);
            check("err_rdata_kept", done_rdata, e.rdata);
        end
        stretch_en = 0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = 2'b00; req_wdata = 8'h00;
        wait_n = 1'b1; stretch_en = 1'b0;
        for (int i = 0; i < 4; i++) port_regs[i] = 8'h00;
        port_regs[2] = 8'hE7;
        clr_mon();
        step(); step();
        check("rst_ready", ready, 1'b1);
        check("rst_done_err", {done, err}, 2'b00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_zaddr", zaddr, 16'h0000);
        check("rst_zdata_o", zdata_o, 8'h00);
        check("rst_oe", zdata_oe, 1'b0);
        check("rst_strobes", {iorq_n, rd_n, wr_n}, 3'b111);
        rst = 1'b0;
        step();

        // Write #83AB
        push(1, 2'd3, 8'h54, 0, 8'h00, LAT, STROBE);
        issue(1, 2'd3, 8'h54);
        accepted(16'h83AB, 1, 8'h54, 0);
        req = 1'b0;
        wait_done();

        // Read #82AB
        push(0, 2'd2, 8'h00, 0, 8'hE7, LAT, STROBE);
        issue(0, 2'd2, 8'h00);
        accepted(16'h82AB, 0, 8'h00, 0);
        req = 1'b0;
        wait_done();
        check("rdata_held", rdata, 8'hE7);

        // Write #81AB with one stretch cycle
        push(1, 2'd1, 8'h3C, 0, 8'h00, LAT + 1, STROBE + 1);
        issue(1, 2'd1, 8'h3C);
        accepted(16'h81AB, 1, 8'h3C, 1);
        req = 1'b0;
        wait_done();

        // Illegal address
        push(1, 2'd0, 8'hFF, 1, 8'hE7, 1, 0);
        issue(1, 2'd0, 8'hFF);
        clr_mon();
        base_cyc = cyc;
        step();
        req = 1'b0;
        check("illegal_done_err", {done, err}, 2'b11);
        check("illegal_strobes", {iorq_n, rd_n, wr_n}, 3'b111);
        check("illegal_zaddr", zaddr, 16'h81AB);
        check("illegal_oe", zdata_oe, 1'b0);
        check("illegal_ready", ready, 1'b1);
        wait_done();
        step();
        check("illegal_done_pulse", done, 1'b0);

        // Back-to-back writes with req held high
        push(1, 2'd3, 8'h10, 0, 8'h00, LAT, STROBE);
        issue(1, 2'd3, 8'h10);
        accepted(16'h83AB, 1, 8'h10, 0);
        req_addr = 2'd2; req_wdata = 8'h0C;
        push(1, 2'd2, 8'h0C, 0, 8'h00, LAT, STROBE);
        wait_done();
        accepted(16'h82AB, 1, 8'h0C, 0);
        req = 1'b0;
        wait_done();

        // Read both back
        push(0, 2'd3, 8'h00, 0, 8'h10, LAT, STROBE);
        issue(0, 2'd3, 8'h00);
        accepted(16'h83AB, 0, 8'h00, 0);
        req = 1'b0;
        wait_done();
        push(0, 2'd2, 8'h00, 0, 8'h0C, LAT, STROBE);
        issue(0, 2'd2, 8'h00);
        accepted(16'h82AB, 0, 8'h00, 0);
        req = 1'b0;
        wait_done();

        // Asynchronous reset in the middle of the strobe
        issue(1, 2'd3, 8'h77);
        accepted(16'h83AB, 1, 8'h77, 0);
        req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_strobe", {iorq_n, wr_n}, 2'b00);
        #2 rst = 1'b1;
        #1;
        check("rst_async_strobes", {iorq_n, rd_n, wr_n}, 3'b111);
        check("rst_async_oe", zdata_oe, 1'b0);
        check("rst_async_ready", ready, 1'b1);
        done_seen = 0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("rst_no_done", done_seen, 1'b0);
        check("rst_ready_after", ready, 1'b1);
        check("rst_write_lost", port_regs[3], 8'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
